// File: rtl/centering_sequencer_pkg.sv
// rtl/centering_sequencer_pkg.sv - shared types and constants for the centering sequencer
package cen_pkg;

  // Sequencer phases, walked in this order for every block
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    DIVIDE   = 3'd2,
    SUBTRACT = 3'd3,
    DONE     = 3'd4
  } cen_state_t;

  // Datapath widths: 16-bit samples, accumulator sized for 32 samples of headroom
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 21;

endpackage

// File: rtl/centering_sequencer_addr_counter.sv
// rtl/centering_sequencer_addr_counter.sv - sample-buffer address counter shared by both read phases
module cen_addr_counter #(
  parameter int N_SAMPLES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);

  assign tc = (addr == LAST);

  // Advance on every read strobe; wrapping at the last sample leaves the
  // counter at 0 ready for the next phase without an explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= tc ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/centering_sequencer.sv
// rtl/centering_sequencer.sv - accumulate/divide/subtract sequencer; CENTERING_ABORT_EN adds block cancel
module centering_sequencer
  import cen_pkg::*;
#(
  parameter int N_SAMPLES = 32,
  parameter int ADDR_W    = 5,
  parameter int DIV_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
`ifdef CENTERING_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              en_sum,
  output logic              en_div,
  output logic              en_sub,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DIV_LOAD = (ADDR_W+1)'(DIV_LAT - 1);

  cen_state_t      state;
  logic [ADDR_W:0] phase_cnt;
  logic            addr_tc;
  logic            start;
  logic            cancel;
  logic            addr_clr;

  assign start = (state == IDLE) && go;

`ifdef CENTERING_ABORT_EN
  assign cancel = abort && busy;
`else
  assign cancel = 1'b0;
`endif

  assign addr_clr = start || cancel;

  cen_addr_counter #(
    .N_SAMPLES (N_SAMPLES),
    .ADDR_W    (ADDR_W)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (addr_clr),
    .inc   (rd_en),
    .addr  (rd_addr),
    .tc    (addr_tc)
  );

  // Phase sequencing with registered strobes; each read phase ends one cycle
  // after its last read so the delayed enable covers the final returned sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      rd_en     <= 1'b0;
      acc_clr   <= 1'b0;
      en_sum    <= 1'b0;
      en_div    <= 1'b0;
      en_sub    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CENTERING_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
`ifdef CENTERING_ABORT_EN
      aborted <= 1'b0;
      if (cancel) begin
        state   <= IDLE;
        rd_en   <= 1'b0;
        en_sum  <= 1'b0;
        en_div  <= 1'b0;
        en_sub  <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            if (go) begin
              state   <= ACCUM;
              acc_clr <= 1'b1;
              rd_en   <= 1'b1;
              busy    <= 1'b1;
            end
          end
          ACCUM: begin
            en_sum <= rd_en;
            if (rd_en && addr_tc) begin
              rd_en <= 1'b0;
            end
            if (!rd_en) begin
              state     <= DIVIDE;
              en_div    <= 1'b1;
              phase_cnt <= DIV_LOAD;
            end
          end
          DIVIDE: begin
            if (phase_cnt == '0) begin
              state  <= SUBTRACT;
              en_div <= 1'b0;
              rd_en  <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt - (ADDR_W+1)'(1);
            end
          end
          SUBTRACT: begin
            en_sub <= rd_en;
            if (rd_en && addr_tc) begin
              rd_en <= 1'b0;
            end
            if (!rd_en) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_centering_sequencer.sv
// tb/tb_centering_sequencer.sv - scoreboard bench for centering_sequencer at DIV_LAT 1 and 3
module tb_centering_sequencer;

  localparam int N  = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          acc_clr;
    logic          en_sum;
    logic          en_div;
    logic          en_sub;
    logic          busy;
    logic          done;
    logic          aborted;
  } vec_t;

  typedef struct {
    int   cyc;
    vec_t v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic go    = 1'b0;
  logic abort = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;

  int lat [2] = '{1, 3};
  bit m_active [2];
  int m_s [2];
  exp_t q0 [$];
  exp_t q1 [$];

  logic          rd_en0, acc_clr0, en_sum0, en_div0, en_sub0, busy0, done0, aborted0;
  logic          rd_en1, acc_clr1, en_sum1, en_div1, en_sub1, busy1, done1, aborted1;
  logic [AW-1:0] rd_addr0, rd_addr1;
  vec_t          act0, act1;

  always #5 clk = ~clk;

  centering_sequencer #(.N_SAMPLES(N), .ADDR_W(AW), .DIV_LAT(1)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
`ifdef CENTERING_ABORT_EN
    .abort   (abort),
    .aborted (aborted0),
`endif
    .rd_en   (rd_en0),
    .rd_addr (rd_addr0),
    .acc_clr (acc_clr0),
    .en_sum  (en_sum0),
    .en_div  (en_div0),
    .en_sub  (en_sub0),
    .busy    (busy0),
    .done    (done0)
  );

  centering_sequencer #(.N_SAMPLES(N), .ADDR_W(AW), .DIV_LAT(3)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
`ifdef CENTERING_ABORT_EN
    .abort   (abort),
    .aborted (aborted1),
`endif
    .rd_en   (rd_en1),
    .rd_addr (rd_addr1),
    .acc_clr (acc_clr1),
    .en_sum  (en_sum1),
    .en_div  (en_div1),
    .en_sub  (en_sub1),
    .busy    (busy1),
    .done    (done1)
  );

`ifndef CENTERING_ABORT_EN
  assign aborted0 = 1'b0;
  assign aborted1 = 1'b0;
`endif

  assign act0 = '{rd_en0, rd_addr0, acc_clr0, en_sum0, en_div0, en_sub0, busy0, done0, aborted0};
  assign act1 = '{rd_en1, rd_addr1, acc_clr1, en_sum1, en_div1, en_sub1, busy1, done1, aborted1};

  // Expected outputs t cycles after go was seen, straight from the block timeline
  function automatic vec_t timeline(input int l, input int t);
    vec_t e;
    e = '0;
    e.acc_clr = (t == 1);
    if (t >= 1 && t <= N) begin
      e.rd_en   = 1'b1;
      e.rd_addr = AW'(t - 1);
    end
    if (t >= N + 2 + l && t <= 2 * N + 1 + l) begin
      e.rd_en   = 1'b1;
      e.rd_addr = AW'(t - (N + 2 + l));
    end
    e.en_sum = (t >= 2 && t <= N + 1);
    e.en_div = (t >= N + 2 && t <= N + 1 + l);
    e.en_sub = (t >= N + 3 + l && t <= 2 * N + 2 + l);
    e.busy   = (t >= 1 && t <= 2 * N + 2 + l);
    e.done   = (t == 2 * N + 3 + l);
    return e;
  endfunction

  task automatic push(input int k, input int c, input vec_t v);
    exp_t x;
    x.cyc = c;
    x.v   = v;
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // One cycle of stimulus; the model predicts the outputs of the next cycle
  task automatic run_cycle(input bit g, input bit a, input bit r);
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    go    = g;
    abort = a;
    rst_n = !r;
    if (r) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_active[k] = 1'b0;
        push(k, cyc, '0);
        push(k, cyc + 1, '0);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int   t;
        bit   idle;
        bit   aborting;
        vec_t e;
        e        = '0;
        t        = cyc - m_s[k];
        idle     = !m_active[k] || (t >= 2 * N + 4 + lat[k]);
        aborting = 1'b0;
        if (idle) m_active[k] = 1'b0;
`ifdef CENTERING_ABORT_EN
        if (a && m_active[k] && t >= 1 && t <= 2 * N + 2 + lat[k]) begin
          m_active[k] = 1'b0;
          aborting    = 1'b1;
        end
`endif
        if (!aborting && idle && g) begin
          m_active[k] = 1'b1;
          m_s[k]      = cyc;
        end
        if (aborting)         e.aborted = 1'b1;
        else if (m_active[k]) e = timeline(lat[k], cyc + 1 - m_s[k]);
        push(k, cyc + 1, e);
      end
    end
  endtask

  task automatic chk(input string name, input int k, input int c, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, c, got, want);
    end
  endtask

  task automatic compare(input int k, input exp_t x, input vec_t a);
    chk("rd_en",   k, x.cyc, int'(a.rd_en),   int'(x.v.rd_en));
    chk("rd_addr", k, x.cyc, int'(a.rd_addr), int'(x.v.rd_addr));
    chk("acc_clr", k, x.cyc, int'(a.acc_clr), int'(x.v.acc_clr));
    chk("en_sum",  k, x.cyc, int'(a.en_sum),  int'(x.v.en_sum));
    chk("en_div",  k, x.cyc, int'(a.en_div),  int'(x.v.en_div));
    chk("en_sub",  k, x.cyc, int'(a.en_sub),  int'(x.v.en_sub));
    chk("busy",    k, x.cyc, int'(a.busy),    int'(x.v.busy));
    chk("done",    k, x.cyc, int'(a.done),    int'(x.v.done));
    chk("aborted", k, x.cyc, int'(a.aborted), int'(x.v.aborted));
  endtask

  // Monitor: pops the prediction for the current cycle and compares mid-cycle
  always @(negedge clk) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      compare(0, x, act0);
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      compare(1, x, act1);
    end
  end

  initial begin
    m_active = '{1'b0, 1'b0};
    m_s      = '{0, 0};
    push(0, 0, '0);
    push(1, 0, '0);

    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0, 1'b0);

    // Single go pulse
    for (int c = 0; c < 22; c++) run_cycle(c == 0, 1'b0, 1'b0);
    // Re-pulsed go while busy and in DONE
    for (int c = 0; c < 22; c++) run_cycle(c == 0 || c == 5 || c == 12, 1'b0, 1'b0);
    // go held high across back-to-back blocks
    for (int c = 0; c < 40; c++) run_cycle(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) run_cycle(1'b0, 1'b0, 1'b0);
    // Reset mid-block, then a fresh block
    for (int c = 0; c < 34; c++) run_cycle(c == 0 || c == 12, 1'b0, c == 8 || c == 9);
    // Abort mid-subtract, then abort on the final en_sub cycle of the DIV_LAT=1 unit
    for (int c = 0; c < 20; c++) run_cycle(c == 0, c == 9, 1'b0);
    for (int c = 0; c < 20; c++) run_cycle(c == 0, c == 11, 1'b0);
    // Abort while idle
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      run_cycle(($urandom % 4) == 0, ($urandom % 24) == 0, ($urandom % 150) == 0);
    end

    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
